regbank_write_scheduler: RTL and testbench

Owns a 2-bank × 4-entry register bank (each entry 3 lanes × 2 bits) and shares its single write port between two requesters via round-robin arbitration with valid/ready handshakes. Provides a bank-clear sequencer and two combinational read ports: port 0 reads bank 0 and port 1 reads bank 1. It replaces a free-running register array plus dynamic-index read muxes wherever that array needs controlled writers.

---
 rtl/regbank_write_scheduler_pkg.sv | 17 +
 rtl/regbank_write_scheduler_rr_arbiter2.sv | 24 ++
 rtl/regbank_write_scheduler.sv | 107 ++++++++++
 tb/tb_regbank_write_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_write_scheduler_pkg.sv
// rtl/regbank_write_scheduler_pkg.sv - shared sizes, entry type and FSM states for the register bank scheduler
package regbank_write_scheduler_pkg;
   localparam int NBANK = 2;
   localparam int NENT  = 4;
   localparam int NLANE = 3;
   localparam int LW    = 2;
   localparam int EW    = NLANE * LW;
   localparam int AW    = $clog2(NENT);

   typedef logic [LW-1:0]     lane_t;
   typedef lane_t [NLANE-1:0] entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/regbank_write_scheduler_rr_arbiter2.sv
// rtl/regbank_write_scheduler_rr_arbiter2.sv - two-way round-robin arbiter, pointer moves only on accepted grants
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);
   // last_gnt holds the index of the most recently accepted requester
   logic last_gnt;

   always_comb begin
      gnt = req;
      if (req == 2'b11)
         gnt = last_gnt ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt <= 1'b1;
      else if (accept && (gnt != 2'b00))
         last_gnt <= gnt[1];
   end
endmodule

// File: rtl/regbank_write_scheduler.sv
// rtl/regbank_write_scheduler.sv - 2x4 register bank with arbitrated write port, bank-clear sequencer and read ports
module regbank_write_scheduler
   import regbank_write_scheduler_pkg::*;
(
   input  logic          CLK,
   input  logic          ASYNCRESETN,
   input  logic          wr0_valid,
   output logic          wr0_ready,
   input  logic          wr0_bank,
   input  logic [AW-1:0] wr0_addr,
   input  logic [EW-1:0] wr0_data,
   input  logic          wr1_valid,
   output logic          wr1_ready,
   input  logic          wr1_bank,
   input  logic [AW-1:0] wr1_addr,
   input  logic [EW-1:0] wr1_data,
   input  logic          clr_valid,
   input  logic          clr_bank,
   output logic          clr_ready,
   input  logic [AW-1:0] raddr0,
   output logic [EW-1:0] rdata0,
   input  logic [AW-1:0] raddr1,
   output logic [EW-1:0] rdata1,
   output logic          busy
);
   entry_t        storage [NBANK][NENT];
   state_t        state, state_n;
   logic [AW-1:0] cnt, cnt_n;
   logic          cbank, cbank_n;

   logic [1:0]    req, gnt;
   logic          wr_fire;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   entry_t        wr_data;

   // Requests are masked outside IDLE so no grant can be issued during a clear
   assign req = (state == IDLE) ? {wr1_valid, wr0_valid} : 2'b00;

   rr_arbiter2 u_arb (
      .clk    (CLK),
      .rst_n  (ASYNCRESETN),
      .req    (req),
      .accept (wr_fire),
      .gnt    (gnt)
   );

   assign wr0_ready = gnt[0];
   assign wr1_ready = gnt[1];
   assign wr_fire   = (wr0_valid & gnt[0]) | (wr1_valid & gnt[1]);
   assign wr_bank   = gnt[1] ? wr1_bank : wr0_bank;
   assign wr_addr   = gnt[1] ? wr1_addr : wr0_addr;
   assign wr_data   = gnt[1] ? wr1_data : wr0_data;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cbank_n   = cbank;
      clr_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            clr_ready = 1'b1;
            if (clr_valid) begin
               state_n = CLEAR;
               cnt_n   = '0;
               cbank_n = clr_bank;
            end
         end
         CLEAR: begin
            busy  = 1'b1;
            cnt_n = cnt + 1'b1;
            if (cnt == AW'(NENT - 1))
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= IDLE;
         cnt   <= '0;
         cbank <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cbank <= cbank_n;
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         for (int b = 0; b < NBANK; b++)
            for (int e = 0; e < NENT; e++)
               storage[b][e] <= '0;
      end else begin
         if (wr_fire)
            storage[wr_bank][wr_addr] <= wr_data;
         if (state == CLEAR)
            storage[cbank][cnt] <= '0;
      end
   end

   assign rdata0 = storage[0][raddr0];
   assign rdata1 = storage[1][raddr1];
endmodule

// File: tb/tb_regbank_write_scheduler.sv
// tb/tb_regbank_write_scheduler.sv - scoreboard bench for regbank_write_scheduler against a behavioural bank model
module tb_regbank_write_scheduler;
   logic       CLK = 1'b0;
   logic       ASYNCRESETN;
   logic       wr0_valid, wr0_ready, wr0_bank;
   logic [1:0] wr0_addr;
   logic [5:0] wr0_data;
   logic       wr1_valid, wr1_ready, wr1_bank;
   logic [1:0] wr1_addr;
   logic [5:0] wr1_data;
   logic       clr_valid, clr_bank, clr_ready;
   logic [1:0] raddr0, raddr1;
   logic [5:0] rdata0, rdata1;
   logic       busy;

   regbank_write_scheduler dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_bank(wr0_bank),
      .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_bank(wr1_bank),
      .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .clr_valid(clr_valid), .clr_bank(clr_bank), .clr_ready(clr_ready),
      .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       r0, r1, cr, bsy;
      logic [5:0] d0, d1;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   logic [5:0] mem [2][4];
   int         last_win;
   int         clear_left;
   int         clear_bk;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int e = 0; e < 4; e++)
            mem[b][e] = 6'h00;
      last_win   = 1;
      clear_left = 0;
      clear_bk   = 0;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("wr0_ready", {5'b0, wr0_ready}, {5'b0, e.r0});
         check("wr1_ready", {5'b0, wr1_ready}, {5'b0, e.r1});
         check("clr_ready", {5'b0, clr_ready}, {5'b0, e.cr});
         check("busy",      {5'b0, busy},      {5'b0, e.bsy});
         check("rdata0",    rdata0,            e.d0);
         check("rdata1",    rdata1,            e.d1);
      end
   end

   task automatic step(input logic v0, input logic b0, input logic [1:0] a0, input logic [5:0] d0,
                       input logic v1, input logic b1, input logic [1:0] a1, input logic [5:0] d1,
                       input logic cv, input logic cb, input logic [1:0] ra0, input logic [1:0] ra1);
      exp_t e;
      @(negedge CLK);
      wr0_valid = v0; wr0_bank = b0; wr0_addr = a0; wr0_data = d0;
      wr1_valid = v1; wr1_bank = b1; wr1_addr = a1; wr1_data = d1;
      clr_valid = cv; clr_bank = cb; raddr0 = ra0; raddr1 = ra1;
      e.r0 = 1'b0; e.r1 = 1'b0;
      if (clear_left > 0) begin
         e.cr = 1'b0; e.bsy = 1'b1;
      end else begin
         e.cr = 1'b1; e.bsy = 1'b0;
         if (v0 && v1) begin
            if (last_win == 1) e.r0 = 1'b1;
            else               e.r1 = 1'b1;
         end else begin
            e.r0 = v0; e.r1 = v1;
         end
      end
      e.d0 = mem[0][ra0];
      e.d1 = mem[1][ra1];
      sb.push_back(e);
      @(posedge CLK);
      if (e.r0) begin
         mem[b0][a0] = d0; last_win = 0;
      end else if (e.r1) begin
         mem[b1][a1] = d1; last_win = 1;
      end
      if (clear_left > 0) begin
         mem[clear_bk][4 - clear_left] = 6'h00;
         clear_left--;
      end else if (cv) begin
         clear_left = 4;
         clear_bk   = cb;
      end
   endtask

   task automatic idle(input logic [1:0] ra0, input logic [1:0] ra1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1);
   endtask

   task automatic reset_pulse();
      @(negedge CLK);
      #3 ASYNCRESETN = 1'b0;
      #1;
      model_reset();
      check("rst_busy",      {5'b0, busy},      6'h00);
      check("rst_clr_ready", {5'b0, clr_ready}, 6'h01);
      check("rst_rdata0",    rdata0,            6'h00);
      check("rst_rdata1",    rdata1,            6'h00);
      @(posedge CLK);
      #1 ASYNCRESETN = 1'b1;
   endtask

   initial begin
      ASYNCRESETN = 1'b0;
      wr0_valid = 0; wr0_bank = 0; wr0_addr = 0; wr0_data = 0;
      wr1_valid = 0; wr1_bank = 0; wr1_addr = 0; wr1_data = 0;
      clr_valid = 0; clr_bank = 0; raddr0 = 0; raddr1 = 0;
      model_reset();
      #3;
      check("init_busy",      {5'b0, busy},      6'h00);
      check("init_clr_ready", {5'b0, clr_ready}, 6'h01);
      check("init_wr0_ready", {5'b0, wr0_ready}, 6'h00);
      check("init_rdata0",    rdata0,            6'h00);
      #9 ASYNCRESETN = 1'b1;

      // contention from reset: grants must alternate 0,1,0,1
      for (int i = 0; i < 4; i++)
         step(1, 1, 0, 6'h01, 1, 1, 0, 6'h3F, 0, 0, 0, 0);
      idle(0, 0);
      check("contention_final", rdata1, 6'h3F);

      // single write then read back on the next cycle
      step(1, 0, 2, 6'h2D, 0, 0, 0, 0, 0, 0, 2, 0);
      idle(2, 0);
      idle(2, 0);
      check("single_write", rdata0, 6'h2D);

      // fill bank 1, then clear it and sweep both banks
      for (int a = 0; a < 4; a++)
         step(1, 1, 2'(a), 6'h3F, 0, 0, 0, 0, 0, 0, 0, 2'(a));
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         step(1, 0, 1, 6'h11, 1, 1, 1, 6'h22, 0, 0, 2, 2'(i));
      for (int a = 0; a < 4; a++)
         idle(2'(a), 2'(a));
      check("clear_keeps_bank0", rdata0, 6'h00);

      // write and clear accepted in the same IDLE cycle
      for (int a = 0; a < 4; a++)
         step(0, 0, 0, 0, 1, 1, 2'(a), 6'h2A, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 3, 6'h15, 1, 1, 0, 3);
      for (int i = 0; i < 6; i++)
         idle(0, 3);

      // reset in the middle of a clear, then a write on the first edge
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
      idle(2, 0);
      idle(2, 0);
      reset_pulse();
      step(1, 1, 1, 6'h33, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 1);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0)
            reset_pulse();
         step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), 6'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), 6'($urandom),
              $urandom_range(0, 11) == 0, $urandom_range(0, 1),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      idle(0, 0);
      @(negedge CLK);
      #4;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
